// File: rtl/rsnn_monitor_pkg.sv
// Shared constants for the RSNN output monitor (spike window counter).
package rsnn_monitor_pkg;

  localparam int unsigned NUM_OUT_DEF = 3;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned WIN_W_DEF   = 8;
  localparam int unsigned WINNER_W    = $clog2(NUM_OUT_DEF);

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rsnn_sat_counter.sv
// Saturating per-neuron spike accumulator with clear.
// sum_c_o is the saturated value including this cycle's increment, for sampling at window close.
module rsnn_sat_counter
  import rsnn_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] sum_c_o
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum_c_o = (cnt_q == MAX) ? MAX : cnt_q + CNT_W'(inc_i);
    cnt_d   = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = sum_c_o;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rsnn_spike_window_counter.sv
// Accumulates RSNN output spikes over a programmable window and posts results via valid/ready.
// Optional argmax/silent outputs are built when RSNN_WINNER_EN is defined.
module rsnn_spike_window_counter
  import rsnn_monitor_pkg::*;
#(
  parameter  int unsigned NUM_OUT = NUM_OUT_DEF,
  parameter  int unsigned CNT_W   = CNT_W_DEF,
  parameter  int unsigned WIN_W   = WIN_W_DEF,
  localparam int unsigned IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_en,
  input  logic [NUM_OUT-1:0]       spikes_in,
  input  logic [WIN_W-1:0]         window_len,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [NUM_OUT*CNT_W-1:0] out_counts,
  output logic                     out_overrun,
  output logic [IDX_W-1:0]         out_winner,
  output logic                     out_silent
);

  logic [WIN_W-1:0]         step_q, step_d, len_q, len_d, eff_len;
  logic                     valid_q, valid_d, overrun_q, overrun_d;
  logic [NUM_OUT*CNT_W-1:0] counts_q, counts_d, acc_sum;
  logic                     close, xfer;

  // Window length is latched on the first sample; zero behaves as one.
  always_comb begin
    eff_len = (step_q == '0) ? window_len : len_q;
    if (eff_len == '0) eff_len = WIN_W'(1);
    close = step_en && (step_q == eff_len - WIN_W'(1));
    xfer  = valid_q && out_ready;
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_acc
    rsnn_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .en_i    (step_en),
      .inc_i   (spikes_in[g]),
      .clr_i   (close),
      .sum_c_o (acc_sum[g*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    step_d    = step_q;
    len_d     = len_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    counts_d  = counts_q;
    if (step_en) begin
      if (step_q == '0) len_d = window_len;
      step_d = close ? '0 : step_q + WIN_W'(1);
    end
    if (xfer) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (close) begin
      valid_d  = 1'b1;
      counts_d = acc_sum;
      if (valid_q && !xfer) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q    <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      counts_q  <= '0;
    end else begin
      step_q    <= step_d;
      len_q     <= len_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      counts_q  <= counts_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_counts  = counts_q;
  assign out_overrun = overrun_q;

`ifdef RSNN_WINNER_EN
  logic [IDX_W-1:0] winner_q, winner_d, best_idx;
  logic [CNT_W-1:0] best_val;
  logic             silent_q, silent_d;

  // Argmax over the closing counts; strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = acc_sum[0 +: CNT_W];
    for (int i = 1; i < int'(NUM_OUT); i++) begin
      if (acc_sum[i*CNT_W +: CNT_W] > best_val) begin
        best_val = acc_sum[i*CNT_W +: CNT_W];
        best_idx = IDX_W'(i);
      end
    end
    winner_d = winner_q;
    silent_d = silent_q;
    if (close) begin
      winner_d = best_idx;
      silent_d = (acc_sum == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner_q <= '0;
      silent_q <= 1'b1;
    end else begin
      winner_q <= winner_d;
      silent_q <= silent_d;
    end
  end

  assign out_winner = winner_q;
  assign out_silent = silent_q;
`else
  assign out_winner = '0;
  assign out_silent = 1'b0;
`endif

endmodule

// File: doc/rsnn_spike_window_counter.md
# rsnn_spike_window_counter

Downstream stage of the RSNN top level: consumes the 3-bit output spike vector one timestep per enabled cycle and accumulates per-neuron spike counts over a programmable window. At each window close it posts the counts, and optionally the winning neuron index, to a result register. The result register is read through a valid/ready handshake. Counting restarts immediately, so no timestep is lost between windows.

## Interface
- NUM_OUT, 3: number of output neurons counted.
- CNT_W, 8: width of each per-neuron count; counts saturate.
- WIN_W, 8: width of window_len.
- clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
- reset  in  1  asynchronous, active-high.
- step_en  in  1  timestep strobe; high = the spikes_in sample is valid this cycle (same enable that drives the RSNN).
- spikes_in  in  NUM_OUT  output_spikes of the RSNN.
- window_len  in  WIN_W  timesteps per window; 0 is treated as 1.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result register holds an unread window.
- out_counts  out  NUM_OUT*CNT_W  neuron i count at bits [i*CNT_W +: CNT_W].
- out_overrun  out  1  sticky: a window result overwrote an unread one.
- out_winner  out  $clog2(NUM_OUT)  argmax neuron index (only with RSNN_WINNER_EN).
- out_silent  out  1  all counts zero (only with RSNN_WINNER_EN).

## Operation
- Working state:
  - NUM_OUT accumulators.
  - Step counter `step` (WIN_W bits).
  - Latched length `len_q`, captured from window_len on the first enabled cycle of each window (step==0); mid-window changes are ignored.
- Enabled cycle:
  - Each accumulator adds spikes_in[i], saturating at 2^CNT_W-1.
  - `step` increments.
- Window close: the enabled cycle where step == effective_len-1.
  - effective_len is window_len on step==0, otherwise len_q.
  - The result register loads the accumulator values including this cycle's spikes.
  - Accumulators and `step` clear to 0.
- Disabled cycle (step_en=0): no state changes except the handshake.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_valid clears next cycle unless a window closes in the same cycle. In that case out_valid stays 1 with the new data, and out_overrun is not set.
- Overrun: a window closes while out_valid=1 and no transfer occurs in that cycle.
  - The result register is overwritten.
  - out_overrun sets to 1.
  - out_overrun clears on the next transfer.
- Winner (RSNN_WINNER_EN):
  - Registered together with out_counts.
  - Index of the maximum count; ties resolve to the lowest index.
  - All-zero counts give winner 0 and out_silent=1.
- Reset mid-window discards partial counts. There is no other flush mechanism.

## Timing
- Reset values: all accumulators, step, len_q, out_counts, out_valid, out_overrun, out_winner 0; out_silent 1.
- Latency: out_valid and the new out_counts appear on the clock edge that ends the closing cycle, i.e. visible the cycle after the last sample.
- With window_len=1, every enabled cycle closes a window; the result stream runs at full rate if out_ready is held high.
- out_counts and out_winner are stable while out_valid=1 until a transfer or an overrun.

## Configuration
- RSNN_WINNER_EN defined:
  - Argmax comparator tree and registered out_winner/out_silent are built.
- RSNN_WINNER_EN undefined:
  - Comparator logic is absent.
  - out_winner is tied to 0 and out_silent is tied to 0.
  - All other behaviour is identical.

## Structure
- Shared package rsnn_monitor_pkg holds:
  - defaults NUM_OUT_DEF=3, CNT_W_DEF=8, WIN_W_DEF=8;
  - localparam WINNER_W = $clog2(NUM_OUT_DEF);
  - count max constant.
- One sub-module, rsnn_sat_counter: CNT_W-bit saturating incrementer with clear. Clear has priority over increment, but the clear value is taken after the result register samples.
- Instantiated NUM_OUT times via generate.

## Test plan
- Basic window: reset, window_len=4, out_ready=1, spikes 3'b001,3'b011,3'b111,3'b001 on 4 enabled cycles.
  - Expected: counts {n2=1,n1=2,n0=4}, out_valid for 1 cycle, winner=0.
- Gaps: same window with step_en low for 5 cycles in between.
  - Expected: identical result, closing only after the 4th enabled sample.
- Saturation: CNT_W=8, window_len=0→ set 255 then spikes 3'b111 constant for 255 steps, plus one window of 300 steps via WIN_W=9.
  - Expected: counts 255, no wrap.
- Overrun: window_len=2, out_ready=0 for 3 windows.
  - Expected: out_overrun=1 after the 2nd close; data equals the 3rd window.
  - Then out_ready=1: transfer, out_overrun=0, out_valid=0.
- Simultaneous: transfer in the same cycle as a window close.
  - Expected: out_valid stays 1 with the new counts, out_overrun=0.
- Reset mid-operation: assert reset after 2 of 4 steps.
  - Expected: all outputs at reset values.
  - The next window counts from zero and applies a new window_len=3.
